// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR fault monitor.
// Optional build macro: TMR_MON_LATCH_EN (sticky FAILED state).
package tmr_pkg;

  localparam int N_REPLICA = 3;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAILED  = 2'd2
  } replica_state_t;

  // Single-bit majority; applied per bit to form the bitwise vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_replica_tracker.sv
// Per-replica disagreement tracker: health FSM, run/recovery counter and
// saturating mismatch counter.
// Optional build macro: TMR_MON_LATCH_EN (FAILED only left via clr/rst).
//
// state   | meaning
// OK      | replica agrees with the vote
// SUSPECT | run of consecutive mismatches shorter than PERSIST
// FAILED  | replica declared failed; run counts matching samples toward recovery
module tmr_replica_tracker
  import tmr_pkg::*;
#(
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic             clr,
  input  logic             mismatch,
  output logic             failed,
  output logic             failed_nxt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int RUN_W = $clog2(PERSIST + 1);

  replica_state_t   state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt;

  // State, run counter and mismatch counter registers; clr beats sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= OK;
      run     <= '0;
      mis_cnt <= '0;
    end else if (clr) begin
      state   <= OK;
      run     <= '0;
      mis_cnt <= '0;
    end else if (sample_valid) begin
      state <= state_nxt;
      run   <= run_nxt;
      if (mismatch && (mis_cnt != {CNT_W{1'b1}}))
        mis_cnt <= mis_cnt + CNT_W'(1);
    end
  end

  // Next-state and run counter for the current sample.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    case (state)
      OK: begin
        if (mismatch) begin
          if (PERSIST == 1) begin
            state_nxt = FAILED;
            run_nxt   = '0;
          end else begin
            state_nxt = SUSPECT;
            run_nxt   = RUN_W'(1);
          end
        end
      end
      SUSPECT: begin
        if (!mismatch) begin
          state_nxt = OK;
          run_nxt   = '0;
        end else if (run == RUN_W'(PERSIST - 1)) begin
          state_nxt = FAILED;
          run_nxt   = '0;
        end else begin
          run_nxt = run + RUN_W'(1);
        end
      end
      FAILED: begin
`ifdef TMR_MON_LATCH_EN
        run_nxt = '0;
`else
        // Any mismatch restarts the recovery count.
        if (mismatch) begin
          run_nxt = '0;
        end else if (run == RUN_W'(PERSIST - 1)) begin
          state_nxt = OK;
          run_nxt   = '0;
        end else begin
          run_nxt = run + RUN_W'(1);
        end
`endif
      end
      default: begin
        state_nxt = OK;
        run_nxt   = '0;
      end
    endcase
  end

  // Failed flag now and after the current sample (used for event detection).
  always_comb begin
    failed     = (state == FAILED);
    failed_nxt = (state_nxt == FAILED);
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// TMR fault monitor top: bitwise vote, per-replica trackers, failed-set
// change detection and a one-entry event buffer toward the logger.
// Optional build macro: TMR_MON_LATCH_EN (sticky FAILED state).
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [WIDTH-1:0]           q_1,
  input  logic [WIDTH-1:0]           q_2,
  input  logic [WIDTH-1:0]           q_3,
  input  logic                       clr,
  output logic [WIDTH-1:0]           voted_q,
  output logic                       no_maj,
  output logic [N_REPLICA-1:0]       failed,
  output logic [N_REPLICA*CNT_W-1:0] mis_cnt,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [N_REPLICA-1:0]       evt_mask,
  output logic                       evt_ovf
);

  logic [WIDTH-1:0]     voted;
  logic                 all_diff;
  logic [N_REPLICA-1:0] mismatch;
  logic [N_REPLICA-1:0] failed_nxt;
  logic                 new_evt;

  // Bitwise majority vote and per-replica disagreement.
  always_comb begin
    voted = '0;
    for (int b = 0; b < WIDTH; b++)
      voted[b] = maj3(q_1[b], q_2[b], q_3[b]);
    all_diff = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);
    mismatch = {q_3 != voted, q_2 != voted, q_1 != voted};
    new_evt  = sample_valid && !clr && (failed_nxt != failed);
  end

  for (genvar i = 0; i < N_REPLICA; i++) begin : g_trk
    tmr_replica_tracker #(
      .PERSIST (PERSIST),
      .CNT_W   (CNT_W)
    ) u_trk (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .clr          (clr),
      .mismatch     (mismatch[i]),
      .failed       (failed[i]),
      .failed_nxt   (failed_nxt[i]),
      .mis_cnt      (mis_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Registered vote result of the last processed sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      voted_q <= '0;
      no_maj  <= 1'b0;
    end else if (sample_valid && !clr) begin
      voted_q <= voted;
      no_maj  <= all_diff;
    end
  end

  // One-entry event buffer; a slot being drained this cycle can be refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_mask  <= '0;
      evt_ovf   <= 1'b0;
    end else begin
      if (clr)
        evt_ovf <= 1'b0;
      if (new_evt) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_mask  <= failed_nxt;
        end else begin
          evt_ovf <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed bench for tmr_fault_monitor (WIDTH=4, PERSIST=3) plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_tmr_fault_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [3:0]  q_1 = '0, q_2 = '0, q_3 = '0;
  logic        clr = 1'b0;
  logic        evt_ready = 1'b1;

  logic [3:0]  voted_q, voted_q_s;
  logic        no_maj, no_maj_s;
  logic [2:0]  failed, failed_s;
  logic [23:0] mis_cnt;
  logic [5:0]  mis_cnt_s;
  logic        evt_valid, evt_valid_s;
  logic [2:0]  evt_mask, evt_mask_s;
  logic        evt_ovf, evt_ovf_s;

  int checks = 0;
  int failures = 0;
  int n_evt = 0;
  logic [2:0] last_mask = '0;

  always #5 clk = ~clk;

  tmr_fault_monitor #(.WIDTH(4), .PERSIST(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .q_1(q_1), .q_2(q_2), .q_3(q_3), .clr(clr),
    .voted_q(voted_q), .no_maj(no_maj), .failed(failed), .mis_cnt(mis_cnt),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_mask(evt_mask),
    .evt_ovf(evt_ovf)
  );

  tmr_fault_monitor #(.WIDTH(4), .PERSIST(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .q_1(q_1), .q_2(q_2), .q_3(q_3), .clr(clr),
    .voted_q(voted_q_s), .no_maj(no_maj_s), .failed(failed_s), .mis_cnt(mis_cnt_s),
    .evt_valid(evt_valid_s), .evt_ready(evt_ready), .evt_mask(evt_mask_s),
    .evt_ovf(evt_ovf_s)
  );

  // Event logger model: records every accepted event.
  always @(posedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_evt = n_evt + 1;
      last_mask = evt_mask;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    sample_valid = 1'b1;
    q_1 = a; q_2 = b; q_3 = c;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_voted", voted_q, 4'h0);
    check("rst_nomaj", no_maj, 1'b0);
    check("rst_failed", failed, 3'b000);
    check("rst_miscnt", mis_cnt, 24'h0);
    check("rst_evt_valid", evt_valid, 1'b0);
    check("rst_evt_mask", evt_mask, 3'b000);
    check("rst_evt_ovf", evt_ovf, 1'b0);

    // All replicas agree.
    repeat (10) sample(4'd5, 4'd5, 4'd5);
    idle(1);
    check("agree_voted", voted_q, 4'd5);
    check("agree_failed", failed, 3'b000);
    check("agree_miscnt", mis_cnt, 24'h0);
    check("agree_no_events", n_evt, 0);

    // Replica 2 persistently wrong.
    sample(4'd2, 4'd7, 4'd2);
    sample(4'd2, 4'd7, 4'd2);
    check("r2_not_yet_failed", failed, 3'b000);
    sample(4'd2, 4'd7, 4'd2);
    check("r2_failed", failed, 3'b010);
    check("r2_evt_valid", evt_valid, 1'b1);
    check("r2_evt_mask", evt_mask, 3'b010);
    check("r2_miscnt", mis_cnt[15:8], 8'd3);
    idle(1);
    check("r2_evt_count", n_evt, 1);
    check("r2_evt_logged_mask", last_mask, 3'b010);
    check("r2_evt_drained", evt_valid, 1'b0);

    do_clr();
    check("clr_failed", failed, 3'b000);
    check("clr_miscnt", mis_cnt, 24'h0);

    // Replica 3: interrupted runs never reach PERSIST.
    sample(4'd2, 4'd2, 4'd9);
    sample(4'd2, 4'd2, 4'd9);
    sample(4'd2, 4'd2, 4'd2);
    sample(4'd2, 4'd2, 4'd9);
    sample(4'd2, 4'd2, 4'd9);
    idle(1);
    check("r3_runs_failed", failed, 3'b000);
    check("r3_runs_miscnt", mis_cnt[23:16], 8'd4);
    check("r3_runs_evt_count", n_evt, 1);
    do_clr();

    // All-different samples: vote 0, every replica mismatches.
    sample(4'd1, 4'd2, 4'd4);
    check("nomaj_flag", no_maj, 1'b1);
    check("nomaj_voted", voted_q, 4'd0);
    check("nomaj_miscnt", mis_cnt, {8'd1, 8'd1, 8'd1});
    sample(4'd1, 4'd2, 4'd4);
    check("nomaj_two_failed", failed, 3'b000);
    sample(4'd1, 4'd2, 4'd4);
    check("nomaj_all_failed", failed, 3'b111);
    idle(1);
    check("nomaj_evt_count", n_evt, 2);
    check("nomaj_evt_mask", last_mask, 3'b111);
    sample(4'd5, 4'd5, 4'd5);
    check("maj_back_flag", no_maj, 1'b0);
    check("maj_back_voted", voted_q, 4'd5);
    do_clr();

    // Backpressure: first event held, second dropped.
    evt_ready = 1'b0;
    repeat (3) sample(4'd6, 4'd3, 4'd3);
    check("bp_first_valid", evt_valid, 1'b1);
    check("bp_first_mask", evt_mask, 3'b001);
    repeat (3) sample(4'd3, 4'd3, 4'd6);
`ifdef TMR_MON_LATCH_EN
    check("bp_failed", failed, 3'b101);
`else
    check("bp_failed", failed, 3'b100);
`endif
    check("bp_mask_stable", evt_mask, 3'b001);
    check("bp_still_valid", evt_valid, 1'b1);
    check("bp_ovf", evt_ovf, 1'b1);
    do_clr();
    check("bp_clr_ovf", evt_ovf, 1'b0);
    check("bp_clr_failed", failed, 3'b000);
    check("bp_clr_keeps_valid", evt_valid, 1'b1);
    check("bp_clr_keeps_mask", evt_mask, 3'b001);
    check("bp_evt_count_held", n_evt, 2);
    evt_ready = 1'b1;
    idle(1);
    check("bp_evt_count", n_evt, 3);
    check("bp_evt_logged_mask", last_mask, 3'b001);
    check("bp_drained", evt_valid, 1'b0);

    // Saturation (CNT_W=2 instance) and recovery behaviour.
    repeat (5) sample(4'd0, 4'd0, 4'd8);
    check("sat_wide_cnt", mis_cnt[23:16], 8'd5);
    check("sat_narrow_cnt", mis_cnt_s[5:4], 2'd3);
    check("sat_failed", failed, 3'b100);
    idle(1);
    check("sat_evt_count", n_evt, 4);
    check("sat_evt_mask", last_mask, 3'b100);
    repeat (2) sample(4'd0, 4'd0, 4'd0);
    check("recov_partial", failed, 3'b100);
    sample(4'd0, 4'd0, 4'd0);
    idle(1);
`ifdef TMR_MON_LATCH_EN
    check("recov_failed", failed, 3'b100);
    check("recov_evt_count", n_evt, 4);
`else
    check("recov_failed", failed, 3'b000);
    check("recov_evt_count", n_evt, 5);
    check("recov_evt_mask", last_mask, 3'b000);
`endif

    // Mid-run reset drops a pending event.
    evt_ready = 1'b0;
    do_clr();
    repeat (3) sample(4'd1, 4'd1, 4'd2);
    check("prerst_valid", evt_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", evt_valid, 1'b0);
    check("midrst_failed", failed, 3'b000);
    check("midrst_miscnt", mis_cnt, 24'h0);
    check("midrst_voted", voted_q, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
